// File: rtl/module_spi_responder_pkg.sv
// Shared types and constants for the SPI responder slice.
package pkg_spi;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } spi_resp_state_t;

    localparam int unsigned SPI_DATA_W     = 8;
    localparam logic [7:0]  SPI_DEFAULT_TX = 8'hFF;

endpackage

// File: rtl/module_spi_responder_if.sv
// SPI pins plus the local TX/RX handshake of the responder, bundled as one port.
interface module_spi_responder_if
    import pkg_spi::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
);
    logic              sclk_i;
    logic              cs_n_i;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic              tx_underrun_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              busy_o;

    modport slave (
        input  sclk_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i,
        output miso_o, miso_oe_o, tx_ready_o, tx_underrun_o, rx_data_o, rx_valid_o, busy_o
    );

    modport master (
        output sclk_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i,
        input  miso_o, miso_oe_o, tx_ready_o, tx_underrun_o, rx_data_o, rx_valid_o, busy_o
    );

endinterface

// File: rtl/module_spi_responder_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with rise/fall detection on the synced value.
module module_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to 0 so a cs_n held low through reset is never mistaken for idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/module_spi_responder.sv
// SPI mode-0 responder: MSB-first RX assembly, TX shifting from a one-deep holding register.
module module_spi_responder
    import pkg_spi::*;
#(
    parameter int unsigned       DATA_W      = SPI_DATA_W,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    module_spi_responder_if.slave  spi
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic sclk_rise, sclk_fall;
    logic cs_n_sync, cs_n_rise, cs_n_fall;
    logic mosi_sync;
    logic sclk_sync;

    module_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi.sclk_i),
        .q_o    (sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    module_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi.cs_n_i),
        .q_o    (cs_n_sync),
        .rise_o (cs_n_rise),
        .fall_o (cs_n_fall)
    );

    module_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi.mosi_i),
        .q_o    (mosi_sync),
        .rise_o (),
        .fall_o ()
    );

    spi_resp_state_t   state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              reload_q, reload_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              oe_q, oe_d;
    logic              load;
    logic              sclk_unused;

    assign sclk_unused = sclk_sync;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        reload_d    = reload_q;
        done_d      = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        oe_d        = oe_q;
        load        = 1'b0;

        // A word completed last cycle is published even if cs_n rises now.
        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        unique case (state_q)
            WAIT_IDLE: begin
                oe_d = 1'b0;
                if (cs_n_sync) state_d = IDLE;
            end
            IDLE: begin
                oe_d = 1'b0;
                if (cs_n_fall) begin
                    load      = 1'b1;
                    oe_d      = 1'b1;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cs_n_rise) begin
                    state_d   = IDLE;
                    oe_d      = 1'b0;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_sync};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        reload_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        // Load sees the pre-write holding state; a same-cycle write then refills it.
        if (load) begin
            tx_shift_d  = hold_full_q ? hold_q : DEFAULT_TX;
            underrun_d  = ~hold_full_q;
            hold_full_d = 1'b0;
        end
        if (spi.tx_valid_i && !hold_full_q) begin
            hold_d      = spi.tx_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            reload_q    <= 1'b0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            reload_q    <= reload_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            oe_q        <= oe_d;
        end
    end

    assign spi.miso_o        = oe_q & tx_shift_q[DATA_W-1];
    assign spi.miso_oe_o     = oe_q;
    assign spi.tx_ready_o    = ~hold_full_q;
    assign spi.tx_underrun_o = underrun_q;
    assign spi.rx_data_o     = rx_data_q;
    assign spi.rx_valid_o    = rx_valid_q;
    assign spi.busy_o        = (state_q == ACTIVE);

endmodule
